hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; every register is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have ports d_rs1 and d_rs2, input, REG_AW each, source registers of the instruction in Decode.
REQ-006 SHALL have port d_rd, input, REG_AW, destination register of the instruction in Decode.
REQ-007 SHALL have port d_regwrite, input, 1, Decode RegWrite.
REQ-008 SHALL have port d_memwrite, input, 1, Decode MemWrite.
REQ-009 SHALL have port d_resultsrc, input, 2, Decode ResultSrc; 01 means load.
REQ-010 SHALL have port e_pctaken, input, 1, branch or jump taken, resolved in Execute.
REQ-011 SHALL have port mem_ready, input, 1, data memory has completed the access held in Memory.
REQ-012 SHALL have ports stall_f, stall_d, stall_e and stall_m, output, 1 each, hold the corresponding pipeline register.
REQ-013 SHALL have ports flush_d and flush_e, output, 1 each, insert a bubble into the corresponding pipeline register.
REQ-014 SHALL have ports fwd_a_e and fwd_b_e, output, 2 each, Execute operand select: 00 register file, 10 Memory ALU result, 01 Writeback result.
REQ-015 SHALL have port stall_cnt, output, CNT_W, saturating count of stall cycles.

Function
REQ-016 SHALL keep an internal shadow of the E, M and W stages; each entry holds valid, rs1, rs2, rd, regwrite, is_load and is_mem.
REQ-017 SHALL advance shadow entries D->E->M->W on every clock edge that is not stalled at that stage.
REQ-018 SHALL load an invalid entry into E whenever flush_e is high.
REQ-019 SHALL drive fwd_a_e as follows: 10 if M is valid with regwrite and rd==E.rs1 and rd!=0; else 01 if the same holds for W; else 00.
REQ-020 SHALL drive fwd_b_e by the rule of REQ-019, applied to E.rs2.
REQ-021 SHALL give M priority over W when both match.
REQ-022 SHALL detect load-use when E is valid with is_load and E.rd!=0 and E.rd equals d_rs1 or d_rs2.
REQ-023 On load-use, SHALL assert stall_f, stall_d and flush_e for exactly one cycle.
REQ-024 SHALL implement a two-state FSM with states RUN and MEM_WAIT.
REQ-025 In RUN, SHALL transition to MEM_WAIT when M is valid with is_mem and mem_ready is 0.
REQ-026 In MEM_WAIT, SHALL assert stall_f, stall_d, stall_e and stall_m.
REQ-027 In MEM_WAIT, SHALL invalidate the entry advancing into W each cycle.
REQ-028 In MEM_WAIT, SHALL return to RUN in the cycle mem_ready is 1; that cycle is unstalled.
REQ-029 SHALL evaluate the memory stall combinationally, so the first wait cycle is stalled with no extra latency.
REQ-030 When e_pctaken is 1 in RUN, SHALL assert flush_d and flush_e for one cycle.
REQ-031 SHALL resolve simultaneous events with priority: memory wait > e_pctaken flush > load-use stall.
REQ-032 SHALL suppress all flushes while stall_m is high.
REQ-033 When e_pctaken and load-use coincide, SHALL flush without stalling.
REQ-034 SHALL never forward or stall on rd==0.
REQ-035 SHALL increment stall_cnt on each cycle where stall_f is 1, saturating at all-ones with no wrap.

Reset
REQ-036 When rst_n is low, SHALL immediately place the FSM in RUN.
REQ-037 When rst_n is low, SHALL immediately invalidate all shadow entries.
REQ-038 When rst_n is low, SHALL immediately clear stall_cnt to 0.
REQ-039 When rst_n is low, SHALL immediately drive all stall and flush outputs to 0 and fwd_a_e/fwd_b_e to 00.
REQ-040 Reset asserted mid-MEM_WAIT SHALL abandon the wait, with no pending state after release.

Structure
REQ-041 SHALL take from the shared package hazard_pkg: the FSM state enum, the forwarding-select constants, the RESULTSRC_LOAD constant and the stage-entry struct typedef.
REQ-042 SHALL instantiate sub-module hazard_stage_reg once per shadow stage; it provides an entry register with stall, flush and async reset.

Verification
REQ-043 Bench SHALL cover: "add x5" in M, E reading x5 -> fwd_a_e=10.
REQ-044 Bench SHALL cover: x5 also written in W -> fwd_a_e remains 10.
REQ-045 Bench SHALL cover: "lw x6" in E, D reads x6 -> one cycle of stall_f=stall_d=flush_e=1, then fwd from W=01.
REQ-046 Bench SHALL cover: e_pctaken=1 in the same cycle as load-use -> flush_d=flush_e=1, stall_f=0.
REQ-047 Bench SHALL cover: store in M with mem_ready low for 3 cycles -> stall_f..stall_m=1 for 3 cycles, stall_cnt+=3, RUN on the 4th cycle.
REQ-048 Bench SHALL cover: rst_n pulsed low during MEM_WAIT -> all outputs 0 and FSM in RUN.
REQ-049 Bench SHALL cover: writes to x0 -> fwd stays 00 and no stall.
REQ-050 Bench SHALL cover: stall_cnt preloaded to near all-ones -> saturates without wrap.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Shadow entries hold register addresses zero-extended to ENTRY_AW bits.
package hazard_pkg;

  localparam int ENTRY_AW = 8;  // widest register address a shadow entry can hold

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic {RUN, MEM_WAIT} state_e;

  typedef struct packed {
    logic                valid;
    logic [ENTRY_AW-1:0] rs1;
    logic [ENTRY_AW-1:0] rs2;
    logic [ENTRY_AW-1:0] rd;
    logic                regwrite;
    logic                is_load;
    logic                is_mem;
  } stage_t;

  // Memory stage wins over writeback; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input stage_t m, input stage_t w,
                                         input logic [ENTRY_AW-1:0] rs);
    if (m.valid && m.regwrite && m.rd != '0 && m.rd == rs) return FWD_MEM;
    if (w.valid && w.regwrite && w.rd != '0 && w.rd == rs) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline entry: flush loads a bubble, stall holds, else advance.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  logic   flush,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (flush)  q <= '0;
    else if (!stall) q <= d;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, branch flush and
// data-memory wait, driven from a shadow copy of the E/M/W stages.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_regwrite,
  input  logic              d_memwrite,
  input  logic [1:0]        d_resultsrc,
  input  logic              e_pctaken,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e state, state_nx;
  stage_t stg [0:3];  // 0 = Decode (live inputs), 1..3 = E, M, W shadows
  stage_t e_ent, m_ent, w_ent;
  logic [3:1] stg_stall, stg_flush;
  logic mem_busy, load_use;
  logic [ENTRY_AW-1:0] rs1_x, rs2_x;

  assign rs1_x = ENTRY_AW'(d_rs1);
  assign rs2_x = ENTRY_AW'(d_rs2);

  assign stg[0] = '{valid:    1'b1,
                    rs1:      rs1_x,
                    rs2:      rs2_x,
                    rd:       ENTRY_AW'(d_rd),
                    regwrite: d_regwrite,
                    is_load:  d_resultsrc == RESULTSRC_LOAD,
                    is_mem:   (d_resultsrc == RESULTSRC_LOAD) || d_memwrite};

  // W never stalls; while M is held, the slot advancing into W is a bubble.
  assign stg_stall = {1'b0, stall_m, stall_e};
  assign stg_flush = {stall_m, 1'b0, flush_e};

  for (genvar i = 1; i <= 3; i++) begin : g_stg
    hazard_stage_reg u_stg (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stg_stall[i]),
      .flush (stg_flush[i]),
      .d     (stg[i-1]),
      .q     (stg[i])
    );
  end

  assign e_ent = stg[1];
  assign m_ent = stg[2];
  assign w_ent = stg[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:      if (m_ent.valid && m_ent.is_mem && !mem_ready) state_nx = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_nx = RUN;
      default:  state_nx = RUN;
    endcase
  end

  // First wait cycle stalls combinationally, before the FSM has moved.
  assign mem_busy = rst_n && ((state == MEM_WAIT) ? !mem_ready
                                                  : (m_ent.valid && m_ent.is_mem && !mem_ready));

  assign load_use = rst_n && e_ent.valid && e_ent.is_load && e_ent.rd != '0 &&
                    (e_ent.rd == rs1_x || e_ent.rd == rs2_x);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (rst_n && e_pctaken) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign fwd_a_e = rst_n ? fwd_sel(m_ent, w_ent, e_ent.rs1) : FWD_RF;
  assign fwd_b_e = rst_n ? fwd_sel(m_ent, w_ent, e_ent.rs2) : FWD_RF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= '0;
    else if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  logic unused_w;
  assign unused_w = ^{w_ent.rs1, w_ent.rs2, w_ent.is_load, w_ent.is_mem};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed hazard scenarios plus random traffic, checked against an
// instruction-level model of the E/M/W pipeline.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] d_rs1, d_rs2, d_rd;
  logic          d_regwrite, d_memwrite;
  logic [1:0]    d_resultsrc;
  logic          e_pctaken, mem_ready;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_regwrite(d_regwrite), .d_memwrite(d_memwrite), .d_resultsrc(d_resultsrc),
    .e_pctaken(e_pctaken), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction record; a bubble is an all-zero record.
  typedef struct {
    bit v;
    int rs1, rs2, rd;
    bit rw, ld, mem;
  } ins_t;

  ins_t ie, im, iw;
  int   cnt;
  int   n_chk = 0, n_pass = 0;
  logic [3:0] x_stall;
  logic [1:0] x_flush, x_fa, x_fb;
  bit   x_memw;

  function automatic ins_t mk(bit v, int rs1, int rs2, int rd, bit rw, bit ld, bit mem);
    ins_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rw = rw; r.ld = ld; r.mem = mem;
    return r;
  endfunction

  function automatic logic [1:0] src(ins_t m, ins_t w, int rs);
    if (m.v && m.rw && m.rd != 0 && m.rd == rs) return 2'b10;
    if (w.v && w.rw && w.rd != 0 && w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic set_d(input int rs1, input int rs2, input int rd,
                       input bit rw, input bit mw, input logic [1:0] rsrc);
    d_rs1 = AW'(rs1); d_rs2 = AW'(rs2); d_rd = AW'(rd);
    d_regwrite = rw; d_memwrite = mw; d_resultsrc = rsrc;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 1'b0, 1'b0, 2'b00);
  endtask

  // Settle just after the falling edge, then compare every output with the model.
  task automatic eval();
    bit lu, pct;
    #1;
    x_stall = '0; x_flush = '0; x_fa = '0; x_fb = '0; x_memw = 1'b0;
    if (rst_n) begin
      pct    = e_pctaken;
      x_memw = im.v && im.mem && !mem_ready;
      lu     = ie.v && ie.ld && ie.rd != 0 && (ie.rd == int'(d_rs1) || ie.rd == int'(d_rs2));
      if (x_memw)   x_stall = 4'hF;
      else if (pct) x_flush = 2'b11;
      else if (lu)  begin x_stall = 4'b0011; x_flush = 2'b01; end
      x_fa = src(im, iw, ie.rs1);
      x_fb = src(im, iw, ie.rs2);
    end
    chk("stall", {stall_m, stall_e, stall_d, stall_f}, x_stall);
    chk("flush", {flush_d, flush_e}, x_flush);
    chk("fwd_a", fwd_a_e, x_fa);
    chk("fwd_b", fwd_b_e, x_fb);
    chk("cnt", stall_cnt, cnt);
  endtask

  task automatic tick();
    ins_t dn;
    @(posedge clk);
    if (rst_n) begin
      dn = mk(1'b1, d_rs1, d_rs2, d_rd, d_regwrite, d_resultsrc == 2'b01,
              d_resultsrc == 2'b01 || d_memwrite);
      if (x_memw) begin
        iw = mk(0, 0, 0, 0, 0, 0, 0);
      end else begin
        iw = im;
        im = ie;
        ie = x_flush[0] ? mk(0, 0, 0, 0, 0, 0, 0) : dn;
      end
      if (x_stall[0] && cnt < CMAX) cnt++;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    eval();
    tick();
  endtask

  // Asynchronous reset mid-cycle; a taken branch is held high to show the gating.
  task automatic do_reset();
    rst_n = 1'b0;
    e_pctaken = 1'b1;
    ie = mk(0, 0, 0, 0, 0, 0, 0); im = ie; iw = ie; cnt = 0;
    eval();
    chk("rst_out", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                    fwd_a_e, fwd_b_e, stall_cnt}, 0);
    @(negedge clk);
    e_pctaken = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; e_pctaken = 1'b0; mem_ready = 1'b1;
    nop();
    @(negedge clk);
    do_reset();

    // ALU result in M forwarded to E
    set_d(0, 0, 5, 1, 0, 2'b00); cyc();
    set_d(5, 0, 7, 1, 0, 2'b00); cyc();
    nop(); eval(); chk("fwd_m", fwd_a_e, 2'b10); tick();

    // x5 written in both M and W: M wins
    do_reset();
    set_d(0, 0, 5, 1, 0, 2'b00); cyc();
    set_d(0, 0, 5, 1, 0, 2'b00); cyc();
    set_d(5, 0, 7, 1, 0, 2'b00); cyc();
    nop(); eval(); chk("fwd_mw", fwd_a_e, 2'b10); tick();

    // load-use: one bubble, then forward from W
    do_reset();
    set_d(1, 0, 6, 1, 0, 2'b01); cyc();
    set_d(6, 0, 8, 1, 0, 2'b00);
    eval(); chk("lu_stall", {stall_f, stall_d, flush_e}, 3'b111); tick();
    eval(); chk("lu_once", stall_f, 0); tick();
    nop(); eval(); chk("lu_fwd_w", fwd_a_e, 2'b01); tick();

    // taken branch coinciding with load-use: flush, no stall
    do_reset();
    set_d(1, 0, 6, 1, 0, 2'b01); cyc();
    set_d(0, 6, 8, 1, 0, 2'b00); e_pctaken = 1'b1;
    eval(); chk("br_lu", {flush_d, flush_e, stall_f}, 3'b110); tick();
    e_pctaken = 1'b0;

    // store waits three cycles in M
    do_reset();
    set_d(2, 3, 0, 0, 1, 2'b00); cyc();
    nop(); cyc();
    mem_ready = 1'b0;
    repeat (3) begin
      eval(); chk("mw_stall", {stall_m, stall_e, stall_d, stall_f}, 4'hF); tick();
    end
    mem_ready = 1'b1;
    eval(); chk("mw_free", {stall_m, stall_e, stall_d, stall_f}, 0);
    chk("mw_cnt", stall_cnt, 3); tick();
    mem_ready = 1'b0;
    eval(); chk("mw_run", stall_f, 0); tick();
    mem_ready = 1'b1;

    // reset pulsed in the middle of a memory wait
    do_reset();
    set_d(2, 3, 0, 0, 1, 2'b00); cyc();
    nop(); cyc();
    mem_ready = 1'b0;
    cyc();
    eval(); chk("wait_held", stall_m, 1); tick();
    do_reset();
    eval(); chk("rst_nopend", stall_f, 0); tick();
    mem_ready = 1'b1;

    // x0 never forwards or stalls
    do_reset();
    set_d(0, 0, 0, 1, 0, 2'b00); cyc();
    set_d(0, 0, 0, 1, 0, 2'b01); cyc();
    set_d(0, 0, 3, 1, 0, 2'b00);
    eval(); chk("x0_nostall", stall_f, 0); chk("x0_fwd", {fwd_a_e, fwd_b_e}, 0); tick();

    // long wait saturates the counter
    do_reset();
    set_d(2, 3, 0, 0, 1, 2'b00); cyc();
    nop(); cyc();
    mem_ready = 1'b0;
    repeat (CMAX + 4) cyc();
    chk("cnt_sat", stall_cnt, CMAX);
    mem_ready = 1'b1;
    cyc();

    // random traffic over a small register set to provoke hazards
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(149) == 0) do_reset();
      set_d($urandom_range(7), $urandom_range(7), $urandom_range(7),
            1'($urandom_range(1)), $urandom_range(7) == 0, 2'($urandom_range(3)));
      e_pctaken = $urandom_range(5) == 0;
      mem_ready = $urandom_range(3) != 0;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
